// File: rtl/noc_inject_arbiter.sv
// noc_inject_arbiter: round-robin, packet-atomic arbiter sharing one NoC injection
// port among NUM_REQ local requesters, with a one-deep registered output stage.
module noc_inject_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int FLIT_WIDTH = 32,
  parameter int IDW        = $clog2(NUM_REQ)
) (
  input  logic                          noc_clk,
  input  logic                          noc_rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*FLIT_WIDTH-1:0] req_flit,
  input  logic [NUM_REQ-1:0]            req_is_header,
  input  logic [NUM_REQ-1:0]            req_is_tail,
  output logic                          sender_valid,
  input  logic                          sender_ready,
  output logic [FLIT_WIDTH-1:0]         sender_flit,
  output logic                          sender_is_header,
  output logic                          sender_is_tail,
  output logic [IDW-1:0]                grant_id,
  output logic                          busy,
  output logic [NUM_REQ-1:0]            proto_err,
  output logic [15:0]                   pkt_count
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  localparam logic [IDW:0] NUM_REQ_W = (IDW+1)'(NUM_REQ);

  state_e                state_q, state_d;
  logic [IDW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]        grant_id_q, grant_id_d;
  logic                  sender_valid_q, sender_valid_d;
  logic [FLIT_WIDTH-1:0] sender_flit_q, sender_flit_d;
  logic                  sender_is_header_q, sender_is_header_d;
  logic                  sender_is_tail_q, sender_is_tail_d;
  logic [NUM_REQ-1:0]    proto_err_q, proto_err_d;
  logic [15:0]           pkt_count_q, pkt_count_d;

  logic                  space_s;
  logic [NUM_REQ-1:0]    cand_s;
  logic                  win_found_s;
  logic [IDW-1:0]        win_idx_s;
  logic [IDW-1:0]        scan_idx_s;
  logic                  scan_hit_s;
  logic                  grant_ok_s;
  logic [IDW-1:0]        take_idx_s;
  logic                  take_s;
  logic [FLIT_WIDTH-1:0] take_flit_s;
  logic                  take_hdr_s;
  logic                  take_tail_s;
  logic [NUM_REQ-1:0]    owner_mask_s;

  // Reduce an index in [0, 2*NUM_REQ) back into [0, NUM_REQ).
  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW:0] v);
    return (v >= NUM_REQ_W) ? IDW'(v - NUM_REQ_W) : v[IDW-1:0];
  endfunction

  // Round-robin search for the first header-presenting requester from rr_ptr.
  always_comb begin
    cand_s      = req_valid & req_is_header;
    win_found_s = 1'b0;
    win_idx_s   = '0;
    scan_idx_s  = '0;
    scan_hit_s  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx_s  = wrap_idx({1'b0, rr_ptr_q} + (IDW+1)'(k));
      scan_hit_s  = ~win_found_s & cand_s[scan_idx_s];
      win_idx_s   = scan_hit_s ? scan_idx_s : win_idx_s;
      win_found_s = win_found_s | scan_hit_s;
    end
  end

  // Ready/take selection: owner while locked, arbitration winner while idle.
  always_comb begin
    space_s    = ~sender_valid_q | sender_ready;
    take_idx_s = (state_q == ST_LOCKED) ? grant_id_q : win_idx_s;
    grant_ok_s = (state_q == ST_LOCKED) | win_found_s;
    req_ready  = '0;
    if (grant_ok_s && space_s && !noc_rst) begin
      req_ready[take_idx_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
    take_s      = |(req_valid & req_ready);
    take_hdr_s  = req_is_header[take_idx_s];
    take_tail_s = req_is_tail[take_idx_s];
    take_flit_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      take_flit_s = (IDW'(i) == take_idx_s) ? req_flit[i*FLIT_WIDTH +: FLIT_WIDTH] : take_flit_s;
    end
  end

  // FSM next state: a header opens a packet unless it is also the tail.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   state_d = (take_s && !take_tail_s) ? ST_LOCKED : ST_IDLE;
      ST_LOCKED: state_d = (take_s && take_tail_s) ? ST_IDLE : ST_LOCKED;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM output decode.
  always_comb begin
    busy = (state_q == ST_LOCKED);
  end

  // Datapath next state: grant bookkeeping, output stage, error flags, counter.
  always_comb begin
    owner_mask_s = '0;
    if (state_q == ST_LOCKED) begin
      owner_mask_s[grant_id_q] = 1'b1;
    end else begin
      owner_mask_s = '0;
    end

    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    if (take_s && (state_q == ST_IDLE)) begin
      grant_id_d = win_idx_s;
      rr_ptr_d   = wrap_idx({1'b0, win_idx_s} + (IDW+1)'(1));
    end else begin
      grant_id_d = grant_id_q;
    end

    sender_flit_d      = sender_flit_q;
    sender_is_header_d = sender_is_header_q;
    sender_is_tail_d   = sender_is_tail_q;
    if (take_s) begin
      sender_valid_d     = 1'b1;
      sender_flit_d      = take_flit_s;
      sender_is_header_d = take_hdr_s;
      sender_is_tail_d   = take_tail_s;
    end else begin
      sender_valid_d = sender_valid_q & ~sender_ready;
    end

    // A non-owner presenting a body flit has lost packet framing; it never gets ready.
    proto_err_d = proto_err_q | (req_valid & ~req_is_header & ~owner_mask_s);
    pkt_count_d = pkt_count_q + {15'd0, sender_valid_q & sender_ready & sender_is_tail_q};
  end

  // FSM state register.
  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers.
  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      rr_ptr_q           <= '0;
      grant_id_q         <= '0;
      sender_valid_q     <= 1'b0;
      sender_flit_q      <= '0;
      sender_is_header_q <= 1'b0;
      sender_is_tail_q   <= 1'b0;
      proto_err_q        <= '0;
      pkt_count_q        <= 16'd0;
    end else begin
      rr_ptr_q           <= rr_ptr_d;
      grant_id_q         <= grant_id_d;
      sender_valid_q     <= sender_valid_d;
      sender_flit_q      <= sender_flit_d;
      sender_is_header_q <= sender_is_header_d;
      sender_is_tail_q   <= sender_is_tail_d;
      proto_err_q        <= proto_err_d;
      pkt_count_q        <= pkt_count_d;
    end
  end

  assign sender_valid     = sender_valid_q;
  assign sender_flit      = sender_flit_q;
  assign sender_is_header = sender_is_header_q;
  assign sender_is_tail   = sender_is_tail_q;
  assign grant_id         = grant_id_q;
  assign proto_err        = proto_err_q;
  assign pkt_count        = pkt_count_q;

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// Bench for noc_inject_arbiter: a cycle-level behavioural model of the arbitration
// rules checked every cycle, plus directed scenarios with hand-computed expectations.
module tb_noc_inject_arbiter;
  localparam int NR = 4;
  localparam int FW = 32;

  logic              clk = 1'b0;
  logic              noc_rst = 1'b1;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_ready;
  logic [NR*FW-1:0]  req_flit = '0;
  logic [NR-1:0]     req_is_header = '0;
  logic [NR-1:0]     req_is_tail = '0;
  logic              sender_valid;
  logic              sender_ready = 1'b1;
  logic [FW-1:0]     sender_flit;
  logic              sender_is_header;
  logic              sender_is_tail;
  logic [1:0]        grant_id;
  logic              busy;
  logic [NR-1:0]     proto_err;
  logic [15:0]       pkt_count;

  noc_inject_arbiter #(.NUM_REQ(NR), .FLIT_WIDTH(FW)) dut (
    .noc_clk(clk), .noc_rst(noc_rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_flit(req_flit),
    .req_is_header(req_is_header), .req_is_tail(req_is_tail),
    .sender_valid(sender_valid), .sender_ready(sender_ready), .sender_flit(sender_flit),
    .sender_is_header(sender_is_header), .sender_is_tail(sender_is_tail),
    .grant_id(grant_id), .busy(busy), .proto_err(proto_err), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [FW-1:0] d;
    logic          h;
    logic          t;
  } flit_t;

  typedef struct {
    int   id;
    logic h;
    logic t;
    int   cyc;
  } take_t;

  flit_t         q [NR][$];
  take_t         tlog[$];
  logic [NR-1:0] present = '0;
  logic [NR-1:0] took = '0;
  logic [NR-1:0] auto_fill = '0;
  bit            rand_gap = 0;
  bit            log_en = 1;
  int            sr_mode = 0;
  int            sr_idx = 0;
  logic [3:0]    sr_pat = 4'b1001;
  int            pkt_seq = 0;
  int            tails_taken = 0;
  int            n_checks = 0;
  int            n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model, compared every cycle ----------------
  int            m_owner = -1;
  int            m_rr = 0;
  int            m_grant = 0;
  int            m_cnt = 0;
  logic          m_sv = 1'b0;
  logic          m_h = 1'b0;
  logic          m_t = 1'b0;
  logic [FW-1:0] m_flit = '0;
  logic [NR-1:0] m_err = '0;
  bit            busy_seen = 0;

  always @(negedge clk) begin
    logic [NR-1:0] exp_ready;
    int            w;
    int            ii;
    bit            space;
    if (cyc >= 1) begin
      chk("sender_valid", 32'(sender_valid), 32'(m_sv));
      chk("sender_flit", sender_flit, m_flit);
      chk("sender_hdr_tail", {30'd0, sender_is_header, sender_is_tail}, {30'd0, m_h, m_t});
      chk("grant_id", 32'(grant_id), 32'(m_grant));
      chk("busy", 32'(busy), 32'(m_owner >= 0));
      chk("proto_err", 32'(proto_err), 32'(m_err));
      chk("pkt_count", 32'(pkt_count), 32'(m_cnt));
    end
    space = !m_sv || sender_ready;
    w = -1;
    if (m_owner >= 0) begin
      w = m_owner;
    end else begin
      for (int k = 0; k < NR; k++) begin
        ii = (m_rr + k) % NR;
        if (w < 0 && req_valid[ii] && req_is_header[ii]) w = ii;
      end
    end
    exp_ready = '0;
    if (!noc_rst && space && w >= 0) exp_ready[w] = 1'b1;
    if (cyc >= 1) chk("req_ready", 32'(req_ready), 32'(exp_ready));
    if (noc_rst) begin
      m_owner = -1; m_rr = 0; m_grant = 0; m_cnt = 0;
      m_sv = 1'b0; m_h = 1'b0; m_t = 1'b0; m_flit = '0; m_err = '0;
    end else begin
      for (int i = 0; i < NR; i++)
        if (i != m_owner && req_valid[i] && !req_is_header[i]) m_err[i] = 1'b1;
      if (m_sv && sender_ready && m_t) m_cnt = (m_cnt + 1) % 65536;
      if (w >= 0 && exp_ready[w] && req_valid[w]) begin
        m_flit = req_flit[w*FW +: FW];
        m_h    = req_is_header[w];
        m_t    = req_is_tail[w];
        m_sv   = 1'b1;
        if (m_owner < 0) begin
          m_grant = w;
          m_rr    = (w + 1) % NR;
          m_owner = req_is_tail[w] ? -1 : w;
        end else if (req_is_tail[w]) begin
          m_owner = -1;
        end
      end else if (sender_ready) begin
        m_sv = 1'b0;
      end
    end
    if (busy === 1'b1) busy_seen = 1;
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_pkt(input int i, input int len);
    flit_t f;
    for (int k = 0; k < len; k++) begin
      f.d = {8'(i), 8'(pkt_seq), 4'(k), 12'($urandom)};
      f.h = (k == 0);
      f.t = (k == len - 1);
      q[i].push_back(f);
    end
    pkt_seq++;
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = present[i];
      if (present[i]) begin
        req_flit[i*FW +: FW] = q[i][0].d;
        req_is_header[i]     = q[i][0].h;
        req_is_tail[i]       = q[i][0].t;
      end else begin
        req_flit[i*FW +: FW] = '0;
        req_is_header[i]     = 1'b0;
        req_is_tail[i]       = 1'b0;
      end
    end
  endtask

  task automatic flush(input int i);
    q[i].delete();
    present[i] = 1'b0;
    drive();
  endtask

  // One clock: note takes before the edge, then advance requester queues after it.
  task automatic step();
    @(negedge clk);
    for (int i = 0; i < NR; i++) begin
      took[i] = req_valid[i] & req_ready[i];
      if (took[i]) begin
        if (log_en) tlog.push_back('{i, q[i][0].h, q[i][0].t, cyc});
        if (q[i][0].t) tails_taken++;
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (took[i]) begin
        void'(q[i].pop_front());
        present[i] = 1'b0;
      end
      if (auto_fill[i] && q[i].size() == 0) push_pkt(i, 1);
      if (!present[i] && q[i].size() != 0 && (!rand_gap || $urandom_range(1, 0) == 1))
        present[i] = 1'b1;
    end
    drive();
    case (sr_mode)
      0:       sender_ready = 1'b1;
      1:       sender_ready = ($urandom_range(99, 0) < 70);
      default: begin sender_ready = sr_pat[sr_idx % 4]; sr_idx++; end
    endcase
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  int exp_rr  [12] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3};
  int exp_sf  [4]  = '{0, 3, 0, 3};
  int exp_bp  [6]  = '{2, 2, 2, 2, 1, 1};

  initial begin
    int   bound;
    int   target;
    bit   drained;
    flit_t bad;

    // Reset with every requester offering a 3-flit packet.
    for (int i = 0; i < NR; i++) begin
      push_pkt(i, 3);
      present[i] = 1'b1;
    end
    drive();
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_sender_valid", 32'(sender_valid), 32'd0);
      chk("rst_pkt_count", 32'(pkt_count), 32'd0);
      chk("rst_grant_id", 32'(grant_id), 32'd0);
    end
    noc_rst = 1'b0;

    // Round-robin fairness: 12 flits back to back, order 0,1,2,3.
    tlog.delete();
    run(16);
    chk("rr_take_count", 32'(tlog.size()), 32'd12);
    for (int k = 0; k < 12 && k < tlog.size(); k++) begin
      chk("rr_order", 32'(tlog[k].id), 32'(exp_rr[k]));
      chk("rr_consecutive", 32'(tlog[k].cyc - tlog[0].cyc), 32'(k));
    end
    chk("rr_pkt_count", 32'(pkt_count), 32'd4);

    // Single-flit packets from 0 and 3: never LOCKED, alternating order.
    tlog.delete();
    busy_seen = 0;
    push_pkt(0, 1); push_pkt(0, 1); push_pkt(3, 1); push_pkt(3, 1);
    run(8);
    chk("sf_take_count", 32'(tlog.size()), 32'd4);
    for (int k = 0; k < 4 && k < tlog.size(); k++) begin
      chk("sf_order", 32'(tlog[k].id), 32'(exp_sf[k]));
      chk("sf_consecutive", 32'(tlog[k].cyc - tlog[0].cyc), 32'(k));
    end
    chk("sf_busy_seen", 32'(busy_seen), 32'd0);
    chk("sf_pkt_count", 32'(pkt_count), 32'd8);

    // Protocol error: requester 1 presents a body flit while not owning the port.
    tlog.delete();
    bad.d = 32'hBAD0_0001; bad.h = 1'b0; bad.t = 1'b1;
    q[1].push_back(bad);
    push_pkt(0, 2);
    run(5);
    chk("perr_flags", 32'(proto_err), 32'h2);
    chk("perr_take_count", 32'(tlog.size()), 32'd2);
    for (int k = 0; k < tlog.size(); k++) chk("perr_taker", 32'(tlog[k].id), 32'd0);
    flush(1);
    run(3);
    chk("perr_sticky", 32'(proto_err), 32'h2);
    chk("perr_pkt_count", 32'(pkt_count), 32'd9);

    // Atomicity under backpressure: requester 2 mid-packet, requester 1 waiting.
    tlog.delete();
    push_pkt(2, 4);
    bound = 0;
    while (tlog.size() == 0 && bound < 20) begin step(); bound++; end
    chk("bp_first_take", 32'(tlog.size() != 0), 32'd1);
    push_pkt(1, 2);
    sr_mode = 2; sr_idx = 0;
    run(20);
    sr_mode = 0;
    run(4);
    chk("bp_take_count", 32'(tlog.size()), 32'd6);
    for (int k = 0; k < 6 && k < tlog.size(); k++) chk("bp_order", 32'(tlog[k].id), 32'(exp_bp[k]));
    chk("bp_pkt_count", 32'(pkt_count), 32'd11);

    // Randomized traffic with random gaps and random backpressure.
    log_en = 0; rand_gap = 1; sr_mode = 1;
    for (int c = 0; c < 1000; c++) begin
      for (int i = 0; i < NR; i++)
        if (q[i].size() == 0 && $urandom_range(3, 0) == 0) push_pkt(i, $urandom_range(4, 1));
      step();
    end
    sr_mode = 0; rand_gap = 0;
    drained = 0;
    for (int b = 0; b < 300 && !drained; b++) begin
      drained = 1;
      for (int i = 0; i < NR; i++) if (q[i].size() != 0) drained = 0;
      if (sender_valid) drained = 0;
      if (!drained) step();
    end
    chk("random_drain", 32'(drained), 32'd1);

    // Counter wrap: fill to 0xFFFF with single-flit packets, then one more.
    target = 65535 - m_cnt;
    tails_taken = 0;
    auto_fill[0] = 1'b1;
    bound = 0;
    while (tails_taken < target && bound < 70000) begin step(); bound++; end
    auto_fill[0] = 1'b0;
    flush(0);
    run(3);
    chk("wrap_ffff", 32'(pkt_count), 32'h0000FFFF);
    push_pkt(0, 1);
    run(4);
    chk("wrap_zero", 32'(pkt_count), 32'd0);

    // Reset while the second flit of a packet is on offer.
    log_en = 1;
    tlog.delete();
    push_pkt(2, 3);
    bound = 0;
    while (tlog.size() == 0 && bound < 20) begin step(); bound++; end
    chk("mid_hdr_taken", 32'(tlog.size()), 32'd1);
    noc_rst = 1'b1;
    step();
    noc_rst = 1'b0;
    flush(2);
    chk("mid_sender_valid", 32'(sender_valid), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_grant_id", 32'(grant_id), 32'd0);
    chk("mid_proto_err", 32'(proto_err), 32'd0);
    tlog.delete();
    push_pkt(1, 1); push_pkt(3, 1);
    run(5);
    chk("mid_take_count", 32'(tlog.size()), 32'd2);
    if (tlog.size() >= 2) begin
      chk("mid_rr_first", 32'(tlog[0].id), 32'd1);
      chk("mid_rr_second", 32'(tlog[1].id), 32'd3);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/noc_inject_arbiter.md
# noc_inject_arbiter

Round-robin, packet-atomic arbiter that shares one NoC node's local injection (sender) port among NUM_REQ local requesters. It sits between the node's processing elements and the router's sender_valid/ready/flit/is_header/is_tail interface. Once a requester wins with a header flit, it holds the port until its tail flit is accepted, so wormhole packets are never interleaved. A one-deep registered output stage decouples requester timing from router backpressure.

## Interface

Parameters:
- NUM_REQ, 4, number of local requesters (2..8)
- FLIT_WIDTH, 32, flit payload width
- IDW, $clog2(NUM_REQ), grant index width (derived, not overridden)

Ports (all logic is on one clock; reset is synchronous and active-high):
- noc_clk  in  1  clock, rising edge
- noc_rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester flit valid
- req_ready  out  NUM_REQ  per-requester flit accepted
- req_flit  in  NUM_REQ*FLIT_WIDTH  requester i occupies bits [i*FLIT_WIDTH +: FLIT_WIDTH]
- req_is_header  in  NUM_REQ  flit is a packet header
- req_is_tail  in  NUM_REQ  flit is a packet tail; header+tail together means a single-flit packet
- sender_valid  out  1  output flit valid, registered
- sender_ready  in  1  router accepts the output flit
- sender_flit  out  FLIT_WIDTH  output flit, registered
- sender_is_header  out  1  registered
- sender_is_tail  out  1  registered
- grant_id  out  IDW  current or most recent owner
- busy  out  1  high in LOCKED
- proto_err  out  NUM_REQ  sticky per-requester protocol error
- pkt_count  out  16  count of tails delivered to the router; wraps

## Operation

Definitions:
- space = ~sender_valid | sender_ready
- take_i = req_valid[i] & req_ready[i]
- At most one req_ready bit is high in any cycle.

IDLE state:
- Candidates are requesters with req_valid & req_is_header.
- The winner is the first candidate scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
- req_ready[winner] = space, in the same cycle, so the header is accepted with zero arbitration bubble.
- On a header take: grant_id <= winner, rr_ptr <= (winner+1) mod NUM_REQ.
- Then go to LOCKED, unless is_tail is also set, in which case stay IDLE.

LOCKED state:
- req_ready[grant_id] = space; all other req_ready bits are 0.
- A take with is_tail set returns the block to IDLE.
- Header bits on flits after the first are forwarded unchanged and not checked.

Output register:
- On any take, load req_flit/is_header/is_tail of the taken requester and set sender_valid <= 1.
- Otherwise, if sender_ready is high, sender_valid <= 0.
- Data is held stable while sender_valid & ~sender_ready.

Protocol error:
- proto_err[i] is set when requester i is not the LOCKED owner and presents req_valid & ~req_is_header.
- That flit is never accepted; the requester stalls.
- proto_err is cleared only by reset.

pkt_count:
- Increments on sender_valid & sender_ready & sender_is_tail.
- Wraps from 0xFFFF to 0x0000.

## Timing

Reset (synchronous; values on the first edge with noc_rst high):
- sender_valid=0, sender_flit=0, sender_is_header=0, sender_is_tail=0
- grant_id=0, busy=0, rr_ptr=0, proto_err=0, pkt_count=0, state=IDLE
- req_ready=0 while noc_rst is high.

Latency and throughput:
- A flit taken in cycle t appears on sender_* in cycle t+1.
- Sustained throughput is 1 flit/cycle while sender_ready stays high.

Backpressure:
- With sender_valid=1 and sender_ready=0, space=0 and all req_ready=0.
- Nothing is overwritten.

Packet boundaries:
- Tail of packet A taken in cycle t, with another header waiting: the next header can be taken at t+1. That gives a back-to-back stream with no idle cycle on sender_valid if sender_ready stays high.
- A single-flit packet takes one cycle and never enters LOCKED.

Reset mid-packet:
- The held flit is discarded and the partial packet is abandoned.
- The router shares noc_rst, so no recovery flit is sent.

busy:
- busy = (state==LOCKED); it is combinational from the state register.

## Test plan

- **Reset values:** assert noc_rst for 3 cycles with all req_valid=1 -> all outputs hold reset values and req_ready stays 0. Release -> requester 0's header is taken first.
- **Round-robin fairness:** all 4 requesters continuously offer 3-flit packets, sender_ready=1 -> grant order 0,1,2,3,0..., 12 flits in 12 consecutive cycles, and pkt_count=4 after the fourth tail.
- **Packet atomicity under backpressure:** requester 2 is mid-packet, requester 1 raises a header, and sender_ready toggles 1,0,0,1 -> only requester 2's flits appear until its tail, with sender_flit stable during the stalls. Requester 1 is granted the cycle after the tail is taken.
- **Single-flit packets:** requesters 0 and 3 each send header+tail flits -> busy is never asserted, output order is 0,3,0,3, and pkt_count increments each cycle.
- **Protocol error:** idle arbiter, requester 1 presents valid with is_header=0 -> req_ready[1]=0, proto_err=4'b0010 the next cycle and staying set. Requester 0's traffic is unaffected.
- **Wrap and mid-packet reset:** preload traffic until pkt_count=0xFFFF, send one more packet -> pkt_count=0x0000. Then assert noc_rst during the second flit of a packet -> sender_valid=0 the next cycle, state IDLE, and rr_ptr=0.
